// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words MSB first from din.
// Define SIPO_PARITY_EN to append one even-parity bit per frame and report par_err.
module sipo_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             shift_en,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             par_err
);

    // valid is a one-cycle strobe with no back-pressure: dout changes on the same
    // edge valid rises, and the consumer must take the word in that cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;

`ifdef SIPO_PARITY_EN
    logic [WIDTH-1:0] shreg;
    logic             par_err_q;

    assign par_err = par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            count     <= '0;
            state     <= IDLE;
            dout      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            par_err_q <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (shift_en) begin
                if (state == PARITY) begin
                    // din is the parity bit here; it never enters the data word.
                    dout      <= shreg;
                    par_err_q <= (^shreg) ^ din;
                    valid     <= 1'b1;
                    count     <= '0;
                    shreg     <= '0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end else begin
                    shreg <= {shreg[WIDTH-2:0], din};
                    count <= count + CNT_W'(1);
                    state <= (count == LAST) ? PARITY : SHIFT;
                    busy  <= 1'b1;
                end
            end
        end
    end
`else
    // Only WIDTH-1 bits need storing: the final bit goes straight into dout.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] word_next;

    assign word_next = {shreg, din};
    assign par_err   = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
            state <= IDLE;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (shift_en) begin
                if (state == SHIFT && count == LAST) begin
                    dout  <= word_next;
                    valid <= 1'b1;
                    count <= '0;
                    shreg <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    shreg <= word_next[WIDTH-2:0];
                    count <= count + CNT_W'(1);
                    state <= SHIFT;
                    busy  <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed table-driven bench for sipo_deser (WIDTH=4); covers both the plain
// build and the SIPO_PARITY_EN build.
module tb_sipo_deser;

    logic       clk;
    logic       reset;
    logic       din;
    logic       shift_en;
    logic       clear;
    logic [3:0] dout;
    logic       valid;
    logic       busy;
    logic       par_err;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       reset;
        logic       clear;
        logic       en;
        logic       din;
        logic [3:0] dout;
        logic       valid;
        logic       busy;
        logic       perr;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    sipo_deser #(.WIDTH(4), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .shift_en (shift_en),
        .clear    (clear),
        .dout     (dout),
        .valid    (valid),
        .busy     (busy),
        .par_err  (par_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    // ---------------- vector table builders ----------------
    function automatic void add(string tag, logic r, logic c, logic e, logic d,
                                logic [3:0] od, logic ov, logic ob, logic op);
        vec_t t;
        t.reset = r; t.clear = c; t.en = e; t.din = d;
        t.dout = od; t.valid = ov; t.busy = ob; t.perr = op; t.tag = tag;
        vecs.push_back(t);
    endfunction

    function automatic void sh(string tag, logic d, logic [3:0] od, logic ov, logic ob, logic op);
        add(tag, 1'b0, 1'b0, 1'b1, d, od, ov, ob, op);
    endfunction

    function automatic void gap(string tag, logic [3:0] od, logic ob, logic op);
        add(tag, 1'b0, 1'b0, 1'b0, 1'b0, od, 1'b0, ob, op);
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input vec_t t);
        @(negedge clk);
        reset = t.reset; clear = t.clear; shift_en = t.en; din = t.din;
        @(posedge clk);
        #1;
        n_vec++;
        if (t.valid) exp_q.push_back(t.dout);
        if (dout !== t.dout || valid !== t.valid || busy !== t.busy || par_err !== t.perr) begin
            n_err++;
            $display("FAIL %s: got dout=%b valid=%b busy=%b par_err=%b, expected dout=%b valid=%b busy=%b par_err=%b",
                     t.tag, dout, valid, busy, par_err, t.dout, t.valid, t.busy, t.perr);
        end
    endtask

    // Long idle stretch: nothing may change and valid must stay low throughout.
    task automatic idle_check(input int n, input logic [3:0] od, input logic op);
        vec_t t;
        for (int i = 0; i < n; i++) begin
            t.reset = 1'b0; t.clear = 1'b0; t.en = 1'b0; t.din = 1'($urandom_range(0, 1));
            t.dout = od; t.valid = 1'b0; t.busy = 1'b0; t.perr = op; t.tag = "idle_hold";
            apply(t);
        end
    endtask

    // ---------------- scoreboard: every valid strobe must match a queued word ----------------
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_valid: got dout=%b, expected no strobe", dout);
            end else begin
                logic [3:0] w;
                w = exp_q.pop_front();
                if (dout !== w) begin
                    n_err++;
                    $display("FAIL sb_word: got dout=%b, expected %b", dout, w);
                end
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        reset = 1'b0; clear = 1'b0; shift_en = 1'b0; din = 1'b0;

        add("reset", 1, 0, 0, 0, 4'b0000, 0, 0, 0);
`ifdef SIPO_PARITY_EN
        sh("p1_b1", 1, 4'b0000, 0, 1, 0);
        sh("p1_b2", 0, 4'b0000, 0, 1, 0);
        sh("p1_b3", 0, 4'b0000, 0, 1, 0);
        sh("p1_b4", 1, 4'b0000, 0, 1, 0);
        sh("p1_par", 0, 4'b1001, 1, 0, 0);
        sh("p2_b1", 1, 4'b1001, 0, 1, 0);
        sh("p2_b2", 0, 4'b1001, 0, 1, 0);
        gap("p2_gap", 4'b1001, 1, 0);
        sh("p2_b3", 0, 4'b1001, 0, 1, 0);
        sh("p2_b4", 0, 4'b1001, 0, 1, 0);
        sh("p2_par_bad", 0, 4'b1000, 1, 0, 1);
        gap("p2_hold", 4'b1000, 0, 1);
        add("clear_keeps_perr", 0, 1, 0, 0, 4'b1000, 0, 0, 1);
        sh("p3_b1", 1, 4'b1000, 0, 1, 1);
        sh("p3_b2", 0, 4'b1000, 0, 1, 1);
        sh("p3_b3", 1, 4'b1000, 0, 1, 1);
        sh("p3_b4", 1, 4'b1000, 0, 1, 1);
        sh("p3_par_ok", 1, 4'b1011, 1, 0, 0);
        sh("p4_b1", 1, 4'b1011, 0, 1, 0);
        sh("p4_b2", 1, 4'b1011, 0, 1, 0);
        sh("p4_b3", 1, 4'b1011, 0, 1, 0);
        sh("p4_b4", 0, 4'b1011, 0, 1, 0);
        sh("p4_par_bad", 0, 4'b1110, 1, 0, 1);
        sh("p5_b1", 1, 4'b1110, 0, 1, 1);
        sh("p5_b2", 1, 4'b1110, 0, 1, 1);
        add("p5_clear_en", 0, 1, 1, 1, 4'b1110, 0, 0, 1);
        sh("p6_b1", 0, 4'b1110, 0, 1, 1);
        sh("p6_b2", 0, 4'b1110, 0, 1, 1);
        sh("p6_b3", 1, 4'b1110, 0, 1, 1);
        sh("p6_b4", 1, 4'b1110, 0, 1, 1);
        sh("p6_par_ok", 0, 4'b0011, 1, 0, 0);
        sh("p7_b1", 1, 4'b0011, 0, 1, 0);
        sh("p7_b2", 1, 4'b0011, 0, 1, 0);
        sh("p7_b3", 1, 4'b0011, 0, 1, 0);
        sh("p7_b4", 0, 4'b0011, 0, 1, 0);
        sh("p7_par_bad", 0, 4'b1110, 1, 0, 1);
        sh("p8_b1", 1, 4'b1110, 0, 1, 1);
        add("p8_reset", 1, 1, 1, 1, 4'b0000, 0, 0, 0);
        sh("p9_b1", 1, 4'b0000, 0, 1, 0);
        sh("p9_b2", 0, 4'b0000, 0, 1, 0);
        sh("p9_b3", 1, 4'b0000, 0, 1, 0);
        sh("p9_b4", 0, 4'b0000, 0, 1, 0);
        add("p9_clear_in_parity", 0, 1, 1, 0, 4'b0000, 0, 0, 0);
        sh("p10_b1", 0, 4'b0000, 0, 1, 0);
        sh("p10_b2", 1, 4'b0000, 0, 1, 0);
        sh("p10_b3", 0, 4'b0000, 0, 1, 0);
        sh("p10_b4", 1, 4'b0000, 0, 1, 0);
        sh("p10_par_ok", 0, 4'b0101, 1, 0, 0);
`else
        sh("t1_b1", 1, 4'b0000, 0, 1, 0);
        sh("t1_b2", 0, 4'b0000, 0, 1, 0);
        sh("t1_b3", 0, 4'b0000, 0, 1, 0);
        sh("t1_b4", 1, 4'b1001, 1, 0, 0);
        gap("t1_after", 4'b1001, 0, 0);
        sh("t2_b1", 1, 4'b1001, 0, 1, 0);
        gap("t2_gap1a", 4'b1001, 1, 0);
        gap("t2_gap1b", 4'b1001, 1, 0);
        sh("t2_b2", 0, 4'b1001, 0, 1, 0);
        gap("t2_gap2a", 4'b1001, 1, 0);
        gap("t2_gap2b", 4'b1001, 1, 0);
        sh("t2_b3", 1, 4'b1001, 0, 1, 0);
        gap("t2_gap3a", 4'b1001, 1, 0);
        gap("t2_gap3b", 4'b1001, 1, 0);
        sh("t2_b4", 0, 4'b1010, 1, 0, 0);
        sh("t3_b1", 1, 4'b1010, 0, 1, 0);
        sh("t3_b2", 0, 4'b1010, 0, 1, 0);
        sh("t3_b3", 1, 4'b1010, 0, 1, 0);
        sh("t3_b4", 0, 4'b1010, 1, 0, 0);
        sh("t3_b5", 1, 4'b1010, 0, 1, 0);
        sh("t3_b6", 1, 4'b1010, 0, 1, 0);
        sh("t3_b7", 1, 4'b1010, 0, 1, 0);
        sh("t3_b8", 1, 4'b1111, 1, 0, 0);
        sh("t4_b1", 1, 4'b1111, 0, 1, 0);
        sh("t4_b2", 1, 4'b1111, 0, 1, 0);
        add("t4_clear_en", 0, 1, 1, 1, 4'b1111, 0, 0, 0);
        sh("t4_b3", 0, 4'b1111, 0, 1, 0);
        sh("t4_b4", 1, 4'b1111, 0, 1, 0);
        sh("t4_b5", 1, 4'b1111, 0, 1, 0);
        sh("t4_b6", 0, 4'b0110, 1, 0, 0);
        sh("t5_b1", 1, 4'b0110, 0, 1, 0);
        sh("t5_b2", 0, 4'b0110, 0, 1, 0);
        add("t5_reset", 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        sh("t5_b3", 0, 4'b0000, 0, 1, 0);
        sh("t5_b4", 0, 4'b0000, 0, 1, 0);
        sh("t5_b5", 1, 4'b0000, 0, 1, 0);
        sh("t5_b6", 1, 4'b0011, 1, 0, 0);
        sh("t6_b1", 1, 4'b0011, 0, 1, 0);
        add("t6_reset_over_clear", 1, 1, 1, 1, 4'b0000, 0, 0, 0);
        sh("t6_b2", 0, 4'b0000, 0, 1, 0);
        sh("t6_b3", 1, 4'b0000, 0, 1, 0);
        sh("t6_b4", 0, 4'b0000, 0, 1, 0);
        sh("t6_b5", 1, 4'b0101, 1, 0, 0);
        add("t6_clear_idle", 0, 1, 0, 0, 4'b0101, 0, 0, 0);
`endif

        foreach (vecs[i]) apply(vecs[i]);

        idle_check(12, 4'b0101, 1'b0);

        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d unconsumed words, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
